// File: rtl/dm633_shifter.sv
// Serialises a framebuffer into a DM633 daisy chain (DCK/DAI/LAT), last channel first.
// Define DM633_FRAMECOUNT_EN to add the 16-bit o_frames completed-frame counter.
module dm633_shifter #(
    parameter int c_ledboards  = 30,
    parameter int c_channels   = c_ledboards * 32,
    parameter int c_addr_w     = $clog2(c_channels),
    parameter int c_bpc        = 12,
    parameter int c_clkdiv     = 2,
    parameter int c_lat_cycles = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bpc-1:0]    i_rdata,
    output logic                o_dck,
    output logic                o_dai,
    output logic                o_lat,
    output logic                o_busy,
    output logic                o_done
`ifdef DM633_FRAMECOUNT_EN
    ,
    output logic [15:0]         o_frames
`endif
);

    localparam int c_div_w = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
    localparam int c_bit_w = (c_bpc > 1) ? $clog2(c_bpc) : 1;
    localparam int c_lat_w = (c_lat_cycles > 1) ? $clog2(c_lat_cycles) : 1;
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
    localparam logic [c_div_w-1:0]  c_div_max   = c_div_w'(c_clkdiv - 1);
    localparam logic [c_bit_w-1:0]  c_bit_max   = c_bit_w'(c_bpc - 1);
    localparam logic [c_lat_w-1:0]  c_lat_max   = c_lat_w'(c_lat_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [c_addr_w-1:0] addr_n;
    logic [c_bpc-1:0]    sreg, sreg_n;
    logic [c_bit_w-1:0]  bit_cnt, bit_cnt_n;
    logic [c_div_w-1:0]  div_cnt, div_cnt_n;
    logic [c_lat_w-1:0]  lat_cnt, lat_cnt_n;
    logic                pending, pending_n;
    logic                dck_n, dai_n;

    always_comb begin
        state_n   = state;
        addr_n    = o_raddr;
        sreg_n    = sreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        lat_cnt_n = lat_cnt;
        pending_n = pending | (i_start && state != S_IDLE);
        dck_n     = 1'b0;
        dai_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_n = S_FETCH;
                    addr_n  = c_last_addr;
                end
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                sreg_n    = i_rdata;
                bit_cnt_n = '0;
                div_cnt_n = '0;
                dai_n     = i_rdata[c_bpc-1];
                state_n   = S_SHIFT;
            end
            S_SHIFT: begin
                // o_dck doubles as the phase flag: low phase then high phase per bit
                dck_n = o_dck;
                dai_n = o_dai;
                if (div_cnt != c_div_max) begin
                    div_cnt_n = div_cnt + 1'b1;
                end else begin
                    div_cnt_n = '0;
                    if (!o_dck) begin
                        dck_n = 1'b1;
                    end else begin
                        dck_n = 1'b0;
                        if (bit_cnt != c_bit_max) begin
                            sreg_n    = sreg << 1;
                            bit_cnt_n = bit_cnt + 1'b1;
                            dai_n     = sreg_n[c_bpc-1];
                        end else begin
                            dai_n = 1'b0;
                            if (o_raddr == '0) begin
                                state_n   = S_LATCH;
                                lat_cnt_n = '0;
                            end else begin
                                addr_n  = o_raddr - 1'b1;
                                state_n = S_FETCH;
                            end
                        end
                    end
                end
            end
            S_LATCH: begin
                if (lat_cnt == c_lat_max) state_n = S_DONE;
                else lat_cnt_n = lat_cnt + 1'b1;
            end
            S_DONE: begin
                if (pending || i_start) begin
                    state_n   = S_FETCH;
                    addr_n    = c_last_addr;
                    pending_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // status outputs are registered copies of the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            o_raddr <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            lat_cnt <= '0;
            pending <= 1'b0;
            o_dck   <= 1'b0;
            o_dai   <= 1'b0;
            o_lat   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_n;
            o_raddr <= addr_n;
            sreg    <= sreg_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_cnt_n;
            lat_cnt <= lat_cnt_n;
            pending <= pending_n;
            o_dck   <= dck_n;
            o_dai   <= dai_n;
            o_lat   <= (state_n == S_LATCH);
            o_busy  <= (state_n != S_IDLE);
            o_done  <= (state_n == S_DONE);
        end
    end

`ifdef DM633_FRAMECOUNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_frames <= '0;
        else if (state == S_DONE) o_frames <= o_frames + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dm633_shifter.sv
// Bench for dm633_shifter: frame-level scoreboard of DAI words plus pending, reset and clkdiv corner cases.
module tb_dm633_shifter;
    localparam int NCH = 32;
    localparam int BPC = 12;

    logic clk = 1'b0;
    logic rst, start, start3;
    logic [4:0]  raddr, raddr3;
    logic [11:0] rdata, rdata3;
    logic dck, dai, lat, busy, done;
    logic dck3, dai3, lat3, busy3, done3;
`ifdef DM633_FRAMECOUNT_EN
    logic [15:0] frames, frames3;
`endif

    always #5 clk = ~clk;

    dm633_shifter #(.c_ledboards(1), .c_clkdiv(1), .c_lat_cycles(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_raddr(raddr), .i_rdata(rdata),
        .o_dck(dck), .o_dai(dai), .o_lat(lat), .o_busy(busy), .o_done(done)
`ifdef DM633_FRAMECOUNT_EN
        , .o_frames(frames)
`endif
    );

    dm633_shifter #(.c_ledboards(1), .c_clkdiv(3), .c_lat_cycles(4)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .o_raddr(raddr3), .i_rdata(rdata3),
        .o_dck(dck3), .o_dai(dai3), .o_lat(lat3), .o_busy(busy3), .o_done(done3)
`ifdef DM633_FRAMECOUNT_EN
        , .o_frames(frames3)
`endif
    );

    // framebuffer with one cycle of read latency
    logic [11:0] mem [NCH];
    always @(posedge clk) begin
        rdata  <= mem[raddr];
        rdata3 <= mem[raddr3];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] word;
        logic [4:0]  addr;
    } exp_t;
    exp_t sbq[$];

    task automatic push_frame();
        exp_t e;
        for (int a = NCH - 1; a >= 0; a--) begin
            e.word = mem[a];
            e.addr = 5'(a);
            sbq.push_back(e);
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int k = 0; k < NCH; k++) begin
            case (pat)
                0: mem[k] = 12'(k);
                1: mem[k] = (k == 0) ? 12'hFFF : 12'h000;
                2: mem[k] = 12'($urandom);
                default: mem[k] = k[0] ? 12'h555 : 12'hAAA;
            endcase
        end
    endtask

    // monitor for the clkdiv=1 instance
    int rises = 0, bitn = 0, lat_cyc = 0, lat_rises = 0, done_cnt = 0, viol = 0;
    logic [11:0] sh = '0;
    logic dck_q = 1'b0, dai_q = 1'b0, lat_q = 1'b0, done_q = 1'b0;
    exp_t e_mon;

    always @(negedge clk) begin
        if (rst) begin
            bitn = 0; dck_q = 0; dai_q = 0; lat_q = 0; done_q = 0;
        end else begin
            if (dck && !dck_q) begin
                rises++;
                sh = {sh[10:0], dai};
                bitn++;
                if (bitn == BPC) begin
                    bitn = 0;
                    if (sbq.size() == 0) begin
                        check("scoreboard_underflow", 32'(sbq.size()), 32'd1);
                    end else begin
                        e_mon = sbq.pop_front();
                        check("dai_word", 32'(sh), 32'(e_mon.word));
                        check("raddr_at_word", 32'(raddr), 32'(e_mon.addr));
                    end
                end
            end
            if (dck_q && dck && dai !== dai_q) viol++;
            if (!busy && (dck || dai || lat)) viol++;
            if (lat && (dck || dai)) viol++;
            if (lat) lat_cyc++;
            if (lat && !lat_q) lat_rises++;
            if (done) done_cnt++;
            if (done && done_q) viol++;
            dck_q = dck; dai_q = dai; lat_q = lat; done_q = done;
        end
    end

    // monitor for the clkdiv=3 instance: phase widths and DAI timing
    int rises3 = 0, len3 = 0, viol3 = 0, done3_cnt = 0;
    logic dck3_q = 1'b0, dai3_q = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (dck3 != dck3_q) begin
                if (dck3_q) begin
                    if (len3 != 3) viol3++;
                end else if (len3 < 3) begin
                    viol3++;
                end
                if (dck3) rises3++;
                len3 = 1;
            end else begin
                len3++;
            end
            if (dai3 !== dai3_q && dck3) viol3++;
            if (done3) done3_cnt++;
            dck3_q = dck3; dai3_q = dai3;
        end
    end

    task automatic clear_mon();
        rises = 0; lat_cyc = 0; lat_rises = 0; done_cnt = 0; viol = 0;
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) start = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if ((which == 0) ? done : done3) break;
            n++;
        end
        if (n >= budget) check("done_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n = 0;
        while (rises < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rises < target) check("rise_timeout", 32'(rises), 32'(target));
    endtask

    typedef struct {
        string name;
        int    pat;
        int    exp_rises;
        int    exp_lat;
        int    exp_done;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{"ramp",      0, NCH * BPC, 4, 1};
        tbl[1] = '{"last_only", 1, NCH * BPC, 4, 1};
        tbl[2] = '{"random",    2, NCH * BPC, 4, 1};
        tbl[3] = '{"alt",       3, NCH * BPC, 4, 1};

        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        fill_mem(0);
        @(negedge clk);
        check("rst_raddr", 32'(raddr), 0);
        check("rst_dck",   32'(dck),   0);
        check("rst_dai",   32'(dai),   0);
        check("rst_lat",   32'(lat),   0);
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            fill_mem(tbl[i].pat);
            clear_mon();
            push_frame();
            pulse(0);
            wait_done(0, 5000);
            repeat (3) @(negedge clk);
            check({tbl[i].name, "_rises"},  32'(rises),      32'(tbl[i].exp_rises));
            check({tbl[i].name, "_lat"},    32'(lat_cyc),    32'(tbl[i].exp_lat));
            check({tbl[i].name, "_latrise"}, 32'(lat_rises), 1);
            check({tbl[i].name, "_done"},   32'(done_cnt),   32'(tbl[i].exp_done));
            check({tbl[i].name, "_sbq"},    32'(sbq.size()), 0);
            check({tbl[i].name, "_viol"},   32'(viol),       0);
            check({tbl[i].name, "_idle"},   32'(busy),       0);
        end

        // several requests during SHIFT collapse to one back-to-back frame
        fill_mem(0);
        clear_mon();
        push_frame();
        pulse(0);
        wait_rises(30, 2000);
        pulse(0); pulse(0); pulse(0);
        push_frame();
        wait_done(0, 5000);
        @(negedge clk);
        check("pend_busy_after_done", 32'(busy), 1);
        check("pend_raddr_restart",   32'(raddr), 32'(NCH - 1));
        @(negedge clk);
        wait_done(0, 5000);
        repeat (50) @(negedge clk);
        check("pend_done_cnt", 32'(done_cnt),   2);
        check("pend_rises",    32'(rises),      32'(2 * NCH * BPC));
        check("pend_latrise",  32'(lat_rises),  2);
        check("pend_idle",     32'(busy),       0);
        check("pend_sbq",      32'(sbq.size()), 0);
        check("pend_viol",     32'(viol),       0);

        // asynchronous reset mid-frame
        clear_mon();
        push_frame();
        pulse(0);
        wait_rises(200, 2000);
        #2 rst = 1'b1;
        #1;
        check("arst_raddr", 32'(raddr), 0);
        check("arst_dck",   32'(dck),   0);
        check("arst_dai",   32'(dai),   0);
        check("arst_busy",  32'(busy),  0);
        check("arst_lat",   32'(lat),   0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        repeat (20) @(negedge clk);
        check("arst_no_latch", 32'(lat_rises), 0);
        check("arst_stays_idle", 32'(busy), 0);
        clear_mon();
        push_frame();
        pulse(0);
        wait_done(0, 5000);
        repeat (3) @(negedge clk);
        check("arst_new_rises",   32'(rises),      32'(NCH * BPC));
        check("arst_new_latrise", 32'(lat_rises),  1);
        check("arst_new_sbq",     32'(sbq.size()), 0);
`ifdef DM633_FRAMECOUNT_EN
        check("frames_after_rst", 32'(frames), 1);
`endif

        // clkdiv=3 instance, two frames
        fill_mem(2);
        rises3 = 0; viol3 = 0; done3_cnt = 0;
        pulse(1);
        wait_done(1, 10000);
        pulse(1);
        wait_done(1, 10000);
        repeat (3) @(negedge clk);
        check("div3_rises", 32'(rises3),    32'(2 * NCH * BPC));
        check("div3_viol",  32'(viol3),     0);
        check("div3_done",  32'(done3_cnt), 2);
        check("div3_idle",  32'(busy3),     0);
`ifdef DM633_FRAMECOUNT_EN
        check("div3_frames", 32'(frames3), 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm633_shifter.md
DM633_SHIFTER -- requirements
Module: dm633_shifter

Interface
REQ-001 SHALL have parameter c_ledboards, default 30, meaning the number of daisy-chained ledboards.
REQ-002 SHALL have parameter c_channels, default c_ledboards*32, meaning total PWM channels (two DM633 per board).
REQ-003 SHALL have parameter c_addr_w, default $clog2(c_channels), meaning the framebuffer address width.
REQ-004 SHALL have parameter c_bpc, default 12, meaning bits per channel.
REQ-005 SHALL have parameter c_clkdiv, default 2, meaning i_clk cycles per DCK half-period (minimum 1).
REQ-006 SHALL have parameter c_lat_cycles, default 4, meaning the LAT high width in i_clk cycles (minimum 1).
REQ-007 SHALL have port i_clk  input  1  the single clock; all logic rising-edge.
REQ-008 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port i_start  input  1  frame transfer request, sampled every cycle.
REQ-010 SHALL have port o_raddr  output  c_addr_w  framebuffer read address (registered).
REQ-011 SHALL have port i_rdata  input  c_bpc  framebuffer read data, valid one cycle after o_raddr.
REQ-012 SHALL have port o_dck  output  1  DM633 data clock.
REQ-013 SHALL have port o_dai  output  1  DM633 serial data.
REQ-014 SHALL have port o_lat  output  1  DM633 latch.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse at frame end.

Function
REQ-017 SHALL implement states IDLE, FETCH, LOAD, SHIFT, LATCH, DONE; all outputs registered.
REQ-018 IDLE: i_start=1 SHALL load the address counter with c_channels-1, drive o_raddr=c_channels-1 and enter FETCH.
REQ-019 FETCH SHALL last 1 cycle (framebuffer registers the address), then go to LOAD.
REQ-020 LOAD SHALL capture i_rdata into a c_bpc-bit shift register and reset the bit counter, then go to SHIFT.
REQ-021 SHIFT SHALL emit c_bpc bits MSB first; per bit, o_dck is low for c_clkdiv cycles with o_dai=shift register MSB, then high for c_clkdiv cycles; the register shifts left when DCK falls.
REQ-022 o_dai SHALL be stable for the whole high phase of o_dck and for at least c_clkdiv cycles before its rising edge.
REQ-023 After the last bit's high phase: address 0 SHALL go to LATCH; otherwise the address SHALL decrement, o_raddr is updated, and the state returns to FETCH.
REQ-024 Channels SHALL be sent from address c_channels-1 down to 0, so address 0 ends nearest the controller.
REQ-025 o_dck SHALL be low in IDLE, FETCH, LOAD, LATCH and DONE; o_dai SHALL be low outside SHIFT.
REQ-026 LATCH SHALL hold o_lat high for exactly c_lat_cycles cycles, then go to DONE.
REQ-027 DONE SHALL pulse o_done for one cycle, then go to IDLE.
REQ-028 Total DCK rising edges per frame SHALL be exactly c_channels*c_bpc.
REQ-029 i_start while busy SHALL set a pending flag (multiple requests collapse to one); on leaving DONE with the flag set, the block SHALL enter FETCH directly, skipping IDLE, and clear the flag.
REQ-030 i_start in DONE SHALL count as pending.
REQ-031 i_rdata SHALL be ignored outside LOAD.

Reset
REQ-032 i_rst SHALL immediately force IDLE with o_raddr=0, o_dck=0, o_dai=0, o_lat=0, o_busy=0, o_done=0, pending=0, and all counters at 0, including mid-frame; a partial frame SHALL NOT latch.

Configuration
REQ-033 With macro DM633_FRAMECOUNT_EN defined, the block SHALL add port o_frames (output, 16 bits): reset 0, incremented in DONE, wrapping 65535->0.
REQ-034 Without DM633_FRAMECOUNT_EN, port o_frames and its counter SHALL be absent, with all other behaviour identical.

Verification (c_ledboards=1, c_clkdiv=1, c_lat_cycles=4 unless stated)
REQ-035 Framebuffer model with mem[k]=k, one i_start pulse -> 384 DCK rises; the first 12 DAI bits are 0x01F (address 31), the last 12 are 0x000; o_lat high 4 cycles; o_done is 1 cycle.
REQ-036 mem[0]=0xFFF and all else 0 -> the last 12 DAI bits are all 1 and all preceding bits are 0; o_raddr sequence is 31,30,...,0.
REQ-037 Three i_start pulses during SHIFT -> exactly one further frame begins in FETCH the cycle after DONE; two o_done pulses total.
REQ-038 i_rst asserted at DCK edge 200 -> outputs reach reset values without waiting for a clock edge, o_lat never rises, and a new i_start produces a full 384-edge frame.
REQ-039 c_clkdiv=3 -> every DCK high and low phase is 3 cycles and o_dai changes only while DCK is low; with DM633_FRAMECOUNT_EN defined, o_frames=2 after two frames.
